// File: rtl/arc4_pkg.sv
// -----------------------------------------------------------------------------
// arc4_pkg
// Shared definitions for the RC4 (ARC4) S-box stages (init, ksa).
//   S_SIZE             : number of entries in the S memory
//   KEY_BYTES_DEFAULT  : default key length in bytes for ksa
//   byte_t             : one S-memory word
//   ksa_state_t        : ksa FSM state encoding
// -----------------------------------------------------------------------------
package arc4_pkg;

    localparam int S_SIZE            = 256;
    localparam int KEY_BYTES_DEFAULT = 3;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        KSA_IDLE,
        KSA_RD_I,
        KSA_CALC_J,
        KSA_RD_J,
        KSA_GET_J,
        KSA_WR_I,
        KSA_WR_J
    } ksa_state_t;

endpackage

// File: rtl/ksa.sv
// -----------------------------------------------------------------------------
// ksa
// RC4 key-scheduling stage. Permutes an externally owned 256-byte S memory
// (already holding the identity permutation) in place:
//   j = 0; for i in 0..255: j += s[i] + key_byte[i mod KEY_BYTES]; swap s[i], s[j]
// Each iteration takes 6 cycles (read i, compute j, read j, capture s[j],
// write i, write j), so a run is busy for exactly 1536 cycles.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   en      : start request, sampled only while rdy=1
//   rdy     : idle and able to accept en
//   key     : cipher key, byte 0 in the top byte, captured on start
//   addr    : S memory address
//   rddata  : S memory read data, valid one cycle after addr with wren=0
//   wrdata  : S memory write data
//   wren    : S memory write enable, write on the same clock edge
// -----------------------------------------------------------------------------
module ksa
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    ksa_state_t             state_q, state_d;
    byte_t                  i_q, i_d;
    byte_t                  j_q, j_d;
    logic [KW-1:0]          k_q, k_d;
    byte_t                  si_q, si_d;
    byte_t                  sj_q, sj_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;

    byte_t                  key_byte;

    // Key byte 0 lives in the most significant byte of the key.
    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k_q == KW'(b)) begin
                key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        key_d   = key_q;

        case (state_q)
            KSA_IDLE: begin
                if (en) begin
                    key_d   = key;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = KSA_RD_I;
                end
            end
            KSA_RD_I: begin
                state_d = KSA_CALC_J;
            end
            KSA_CALC_J: begin
                // rddata holds s[i] here (one-cycle read latency).
                si_d    = rddata;
                j_d     = j_q + rddata + key_byte;
                state_d = KSA_RD_J;
            end
            KSA_RD_J: begin
                state_d = KSA_GET_J;
            end
            KSA_GET_J: begin
                sj_d    = rddata;
                state_d = KSA_WR_I;
            end
            KSA_WR_I: begin
                state_d = KSA_WR_J;
            end
            KSA_WR_J: begin
                if (i_q == 8'(S_SIZE - 1)) begin
                    state_d = KSA_IDLE;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = (k_q == KW'(KEY_BYTES - 1)) ? '0 : k_q + KW'(1);
                    state_d = KSA_RD_I;
                end
            end
            default: begin
                state_d = KSA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= KSA_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
        end
    end

    // Memory-side outputs depend only on registered state so the memory
    // interface has no combinational path from en or rddata.
    always_comb begin
        rdy    = 1'b0;
        addr   = '0;
        wrdata = '0;
        wren   = 1'b0;
        case (state_q)
            KSA_IDLE: rdy  = 1'b1;
            KSA_RD_I: addr = i_q;
            KSA_RD_J: addr = j_q;
            KSA_WR_I: begin
                addr   = i_q;
                wrdata = sj_q;
                wren   = 1'b1;
            end
            KSA_WR_J: begin
                addr   = j_q;
                wrdata = si_q;
                wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
